// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes it big-endian into
// instruction memory from address 0, verifies an XOR checksum, then releases the core.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MAX_WORDS = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state;
    logic [7:0]            len_hi;
    logic [ADDR_WIDTH-3:0] len_m1;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [7:0]            csum;
    logic [15:0]           n_words;
    logic                  xfer;

    assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHECK);
    assign xfer     = in_valid && in_ready;
    assign n_words  = {len_hi, in_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            len_hi    <= '0;
            len_m1    <= '0;
            cnt       <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LEN_HI;
                        cnt   <= '0;
                        csum  <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= in_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        // Store N-1 so the last byte index is {N-1, 2'b11} without a wider counter.
                        len_m1 <= (ADDR_WIDTH-2)'(n_words - 16'd1);
                        if (n_words == 16'd0 || 32'(n_words) > MAX_WORDS) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt;
                        mem_wdata <= in_data;
                        csum      <= csum ^ in_data;
                        if (cnt == {len_m1, 2'b11}) begin
                            state <= S_CHECK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        if (in_data == csum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        state     <= S_LEN_HI;
                        cnt       <= '0;
                        csum      <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the byte-addressed instruction memory that the instruction fetch unit reads.
- Accepts a framed byte stream over a valid/ready handshake and writes instruction bytes big-endian from address 0.
- Verifies an XOR checksum, then releases the CPU from reset.

Parameters:
ADDR_WIDTH, 10, byte address width of instruction memory; capacity 2^ADDR_WIDTH bytes.
MAX_WORDS, 2^(ADDR_WIDTH-2), largest accepted word count; derived localparam, not overridable.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse to begin or restart a load.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  byte write enable to instruction memory.
- mem_addr  out  ADDR_WIDTH  byte address.
- mem_wdata  out  8  byte to write.
- cpu_reset  out  1  hold-reset to the processor core.
- done  out  1  load completed and checksum matched.
- error  out  1  load rejected.

Behaviour:
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - 4*N instruction bytes; each word is sent MSB first.
  - 1 checksum byte: XOR of all 4*N instruction bytes. The length bytes are not included.
- Handshake: a byte transfers on a posedge where in_valid and in_ready are both 1. in_ready is purely a function of state:
  - 1 in LEN_HI, LEN_LO, DATA, CHECK.
  - 0 in IDLE, DONE, ERROR.
- Reset: takes effect regardless of state, including mid-transfer. On the next posedge:
  - state is IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - byte counter=0, checksum accumulator=0.
- States:
  - IDLE: start -> LEN_HI; clear counter and checksum.
  - LEN_HI: on transfer, latch the high byte -> LEN_LO.
  - LEN_LO: on transfer, latch the low byte. If N==0 or N>MAX_WORDS -> ERROR; otherwise -> DATA.
  - DATA: on each transfer, write the byte, XOR it into the checksum, increment the counter. After the transfer of byte 4*N-1 -> CHECK.
  - CHECK: on transfer, a byte equal to the accumulated checksum -> DONE; otherwise -> ERROR.
  - DONE: done=1, cpu_reset=0. start -> LEN_HI, with done cleared and cpu_reset=1 from the next cycle.
  - ERROR: error=1, cpu_reset=1. start -> LEN_HI, with error cleared.
- start is ignored in LEN_HI, LEN_LO, DATA and CHECK.
- Memory write timing: registered, one cycle after the transfer.
  - For a DATA transfer at posedge t, mem_we=1, mem_addr=k and mem_wdata=byte are presented from t until t+1. k is the 0-based byte index.
  - The memory samples the write at posedge t+1.
  - mem_we=0 in every other cycle. mem_addr and mem_wdata hold their last values when mem_we=0.
- Addressing: word i, byte j (j=0 is the MSB) goes to address 4i+j. The counter never wraps, because N<=MAX_WORDS bounds it to 2^ADDR_WIDTH-1.
- Stalls: in_valid=0 for any number of cycles freezes all state. No write occurs and no counter change occurs.
- The final DATA write (mem_we for the last byte) occurs in the same cycle the CHECK byte may be offered. A checksum byte transferring in that cycle is legal.
- Checksum compare: the compare uses the accumulator including the last data byte.
- cpu_reset deassertion: on the posedge that enters DONE. Therefore the last memory write is completed no later than the first fetch.
- done and error are never both 1.

Test Plan:
1. Reset test: assert reset for 2 cycles in arbitrary state -> all outputs and internal state at their reset values, cpu_reset=1, in_ready=0.
2. Good load:
   - Stimulus: start, then 00 03, CA 0F 33 55, 00 33 0F FF, 20 04 00 08, checksum 4C, with in_valid held high.
   - Response: 12 writes to addresses 0..11 with those bytes in order, done=1, cpu_reset=0, no further writes.
   - Memory words read back as 0xCA0F3355, 0x00330FFF, 0x20040008.
3. Bad checksum: same frame with checksum 4D -> all 12 writes occur, then error=1, done=0, cpu_reset stays 1.
4. Length rejection (ADDR_WIDTH=10):
   - N=0x0000 -> ERROR right after LEN_LO, zero writes.
   - N=0x0101 (257 > 256) -> ERROR, zero writes.
   - N=0x0100 -> accepted and loads addresses 0..1023.
5. Stalls and mid-load reset:
   - Good frame from test 2 with random in_valid gaps -> identical write sequence and DONE.
   - Reset pulsed after the 5th data byte -> IDLE, no write in the cycle after reset.
   - A subsequent start plus full frame loads correctly.
6. Start handling:
   - start pulsed during DATA -> ignored, load completes normally.
   - start in DONE -> cpu_reset=1 and done=0 next cycle; a new frame 00 01, 00 00 00 00, 00 overwrites addresses 0..3 and reaches DONE.
